// File: rtl/jtag_dr_scan_master.sv
// Host-side JTAG sequencer: TAP reset or one LEN-bit DR scan, RTI to RTI.
// TCK is a divided clk; TMS/TDI launch on the falling edge, TDO samples on the rising edge.
module jtag_dr_scan_master #(
    parameter int LEN     = 4,
    parameter int CLK_DIV = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start_scan,
    input  logic           start_reset,
    input  logic [LEN-1:0] tx_data,
    input  logic           tdo,
    output logic           tck,
    output logic           tms,
    output logic           tdi,
    output logic           busy,
    output logic           done,
    output logic [LEN-1:0] rx_data
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2((LEN > 5 ? LEN : 5) + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_TLR,
        S_RTI_GO,
        S_SEL,
        S_CAP,
        S_TO_SH,
        S_SHIFT,
        S_UPD,
        S_RTI_END
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [DW-1:0]   r_div;
    logic [BW-1:0]   r_bit;
    logic [BW-1:0]   w_bit_nx;
    logic            r_tck;
    logic            r_tms;
    logic            r_tdi;
    logic            r_done;
    logic [LEN-1:0]  r_sr;
    logic [LEN-1:0]  r_rx;
    logic [LEN-1:0]  w_sr_sh;
    logic            w_ph_end;
    logic            w_rise;
    logic            w_fall;
    logic            w_start;
    logic            w_tms_nx;
    logic            w_tdi_nx;

    assign w_ph_end = (r_div == DW'(CLK_DIV - 1));
    assign w_rise   = (r_state != S_IDLE) && !r_tck && w_ph_end;
    assign w_fall   = (r_state != S_IDLE) && r_tck && w_ph_end;
    assign w_start  = start_reset | start_scan;
    assign w_sr_sh  = (r_sr << 1) | LEN'(tdo);

    always_comb begin
        w_state_nx = r_state;
        w_bit_nx   = r_bit;
        unique case (r_state)
            S_IDLE: begin
                if (start_reset) begin
                    w_state_nx = S_TLR;
                    w_bit_nx   = '0;
                end else if (start_scan) begin
                    w_state_nx = S_SEL;
                end
            end
            S_TLR: begin
                if (w_fall) begin
                    if (r_bit == BW'(4)) w_state_nx = S_RTI_GO;
                    else w_bit_nx = r_bit + BW'(1);
                end
            end
            S_RTI_GO: if (w_fall) w_state_nx = S_IDLE;
            S_SEL:    if (w_fall) w_state_nx = S_CAP;
            S_CAP:    if (w_fall) w_state_nx = S_TO_SH;
            S_TO_SH: begin
                if (w_fall) begin
                    w_state_nx = S_SHIFT;
                    w_bit_nx   = '0;
                end
            end
            S_SHIFT: begin
                if (w_fall) begin
                    if (r_bit == BW'(LEN - 1)) w_state_nx = S_UPD;
                    else w_bit_nx = r_bit + BW'(1);
                end
            end
            S_UPD:     if (w_fall) w_state_nx = S_RTI_END;
            S_RTI_END: if (w_fall) w_state_nx = S_IDLE;
            default:   w_state_nx = S_IDLE;
        endcase

        // Pin values for the period about to start
        w_tms_nx = 1'b0;
        unique case (w_state_nx)
            S_TLR, S_SEL, S_UPD: w_tms_nx = 1'b1;
            S_SHIFT: w_tms_nx = (w_bit_nx == BW'(LEN - 1));
            default: w_tms_nx = 1'b0;
        endcase
        w_tdi_nx = (w_state_nx == S_SHIFT) && r_sr[LEN-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div  <= '0;
            r_bit  <= '0;
            r_tck  <= 1'b0;
            r_tms  <= 1'b0;
            r_tdi  <= 1'b0;
            r_done <= 1'b0;
            r_sr   <= '0;
            r_rx   <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                r_div <= '0;
                if (w_start) begin
                    r_sr  <= tx_data;
                    r_bit <= w_bit_nx;
                    r_tms <= w_tms_nx;
                end
            end else begin
                r_div <= w_ph_end ? '0 : r_div + DW'(1);
                if (w_rise) begin
                    r_tck <= 1'b1;
                    if (r_state == S_SHIFT) r_sr <= w_sr_sh;
                end
                if (w_fall) begin
                    r_tck <= 1'b0;
                    r_tms <= w_tms_nx;
                    r_tdi <= w_tdi_nx;
                    r_bit <= w_bit_nx;
                    if (w_state_nx == S_IDLE) begin
                        r_done <= 1'b1;
                        if (r_state == S_RTI_END) r_rx <= r_sr;
                    end
                end
            end
        end
    end

    assign tck     = r_tck;
    assign tms     = r_tms;
    assign tdi     = r_tdi;
    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign rx_data = r_rx;

endmodule
